// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   OP_*    : funct3 encodings of the M-extension instructions
//   state_t : unit FSM states
//   XLEN    : default datapath width
package rv32_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling for the multiply/divide unit.
// Entry side: turns raw operands into magnitudes plus sign flags,
// according to the signedness of the requested op.
// Exit side: applies sign correction to the unsigned iteration result
// and selects the architectural result for the latched op.
//   op, a, b          : raw request (entry)
//   a_mag, b_mag      : operand magnitudes
//   a_neg, b_neg      : operand treated as negative
//   op_q, *_neg_q     : latched op and sign flags (exit)
//   acc               : 2*WIDTH accumulator ({rem,quot} for divide)
//   res               : sign-corrected, selected result
module muldiv_sign_fix import rv32_pkg::*; #(
  parameter int WIDTH = XLEN
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  output logic               a_neg,
  output logic               b_neg,
  input  logic [2:0]         op_q,
  input  logic               a_neg_q,
  input  logic               b_neg_q,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   res
);
  logic a_signed, b_signed, flip;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_u, rem_u, quot_s, rem_s;

  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    a_neg = a_signed & a[WIDTH-1];
    b_neg = b_signed & b[WIDTH-1];
    // Most negative value negates to itself, which is its correct magnitude
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_comb begin
    flip   = a_neg_q ^ b_neg_q;
    quot_u = acc[WIDTH-1:0];
    rem_u  = acc[2*WIDTH-1:WIDTH];
    prod_s = flip ? -acc : acc;
    quot_s = flip ? -quot_u : quot_u;
    // Remainder follows the dividend's sign
    rem_s  = a_neg_q ? -rem_u : rem_u;
    case (op_q)
      OP_MUL:                       res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              res = quot_s;
      default:                      res = rem_s;
    endcase
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One shift-add (multiply) or
// restoring-subtract (divide) step per cycle; WIDTH steps per op.
// Divide-by-zero and signed overflow complete without iterating.
//   clk, rst          : clock, async active-high reset
//   start, op         : request (sampled only when idle), funct3
//   rs1_val, rs2_val  : operands A and B
//   rd_in             : destination register
//   busy              : unit occupied
//   done, we_out      : one-cycle writeback pulse
//   result, rd_out    : registered result and destination
module muldiv_unit import rv32_pkg::*; #(
  parameter int WIDTH  = XLEN,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  rs1_val,
  input  logic [WIDTH-1:0]  rs2_val,
  input  logic [ADDR_W-1:0] rd_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [ADDR_W-1:0] rd_out,
  output logic              we_out
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               a_neg_q, b_neg_q;
  logic [WIDTH-1:0]   bmag_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;

  logic [WIDTH-1:0]   a_mag, b_mag, res_calc, fast_res;
  logic               a_neg, b_neg;
  logic               b_zero, ovf, fast, last;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign (
    .op      (op),
    .a       (rs1_val),
    .b       (rs2_val),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .a_neg   (a_neg),
    .b_neg   (b_neg),
    .op_q    (op_q),
    .a_neg_q (a_neg_q),
    .b_neg_q (b_neg_q),
    .acc     (acc_nxt),
    .res     (res_calc)
  );

  // Fast paths, evaluated on the raw request
  always_comb begin
    b_zero   = (rs2_val == '0);
    ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1_val == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_val == '1);
    fast     = op[2] && (b_zero || ovf);
    if (b_zero) fast_res = op[1] ? rs1_val : '1;
    else        fast_res = op[1] ? '0 : rs1_val;
  end

  // One iteration step. acc holds {partial product, multiplier} for
  // multiply and {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag_q} : '0);
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, bmag_q};
    // Without a borrow the difference is below the divisor, so bit WIDTH is clear
    div_ge   = ~(div_diff[WIDTH+1] | div_diff[WIDTH]);
    if (op_q[2])
      acc_nxt = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                       : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      bmag_q  <= '0;
      acc     <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q    <= op;
          rd_out  <= rd_in;
          a_neg_q <= a_neg;
          b_neg_q <= b_neg;
          bmag_q  <= b_mag;
          acc     <= {{WIDTH{1'b0}}, a_mag};
          cnt     <= CNT_W'(WIDTH);
          if (fast) result <= fast_res;
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_W'(1);
          // Final step: register the corrected result on the way into DONE
          if (last) result <= res_calc;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign we_out = done;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want no done pending");
      end else begin
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        chk("we_out", {31'b0, we_out}, 32'd1);
      end
    end
  end

  // Issue one op at cycle t, measure done latency and the busy window,
  // then check that result/rd_out hold afterwards. Optionally pulses a
  // second start with other operands at t+5.
  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int lat, input bit inject = 1'b0);
    int  k;
    bit  seen, busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    sbq.push_back('{exp, rd});
    @(negedge clk);
    start = 1'b0; op = ~o; rs1_val = $urandom; rs2_val = $urandom; rd_in = ~rd;
    k = 1; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && k <= 40) begin
      if (inject && k == 5) begin
        start = 1'b1; op = OP_DIVU; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd1;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done within 40 cycles want done at %0d", name, lat);
    end else begin
      chk({name, "_latency"}, 32'(k), 32'(lat));
      chk({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    end
    @(negedge clk);
    chk({name, "_idle"}, {31'b0, busy}, 32'd0);
    chk({name, "_hold"}, result, exp);
    chk({name, "_rdhold"}, {27'b0, rd_out}, {27'b0, rd});
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_done",   {31'b0, done},   32'd0);
    chk("rst_we",     {31'b0, we_out}, 32'd0);
    chk("rst_result", result,          32'd0);
    chk("rst_rd",     {27'b0, rd_out}, 32'd0);
    rst = 1'b0;

    run("mul",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
    run("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33);
    run("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33);
    run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33);
    run("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33);
    run("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run("div_pn", OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 33);
    run("rem_pn", OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1,         33);
    run("divu",   OP_DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        33);
    run("remu",   OP_REMU,   32'd100,       32'd7,         5'd12, 32'd2,         33);
    run("div0",   OP_DIV,    32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run("remu0",  OP_REMU,   32'd5,         32'd0,         5'd14, 32'd5,         1);
    run("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);
    run("ign",    OP_MUL,    32'd12345,     32'd1000,      5'd17, 32'd12345000,  33, 1'b1);

    // Asynchronous reset in the middle of an iterating op: no writeback
    @(negedge clk);
    start = 1'b1; op = OP_MUL; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   {31'b0, busy},   32'd0);
    chk("arst_done",   {31'b0, done},   32'd0);
    chk("arst_result", result,          32'd0);
    chk("arst_rd",     {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", OP_MULHU, 32'h0001_0000, 32'h0003_0000, 5'd21, 32'd3, 33);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
